// File: rtl/qs_range_stack_if.sv
// qs_range_stack_if: push/pop command and status bundle between sort controller (master) and stack (slave)
interface qs_range_stack_if #(parameter int WORD_SIZE = 16);
  logic                 push_en;
  logic                 pop_en;
  logic [WORD_SIZE-1:0] stack_data_in1;
  logic [WORD_SIZE-1:0] stack_data_in2;
  logic [WORD_SIZE-1:0] stack_data_out1;
  logic [WORD_SIZE-1:0] stack_data_out2;
  logic [WORD_SIZE-1:0] stack_pointer;
  logic [4:0]           count;
  logic                 busy;
  logic                 done;
  logic                 full;
  logic                 empty;
  logic                 overflow_err;
  logic                 underflow_err;
  logic                 protocol_err;
  modport master (
    output push_en, pop_en, stack_data_in1, stack_data_in2,
    input  stack_data_out1, stack_data_out2, stack_pointer, count, busy, done,
           full, empty, overflow_err, underflow_err, protocol_err
  );
  modport slave (
    input  push_en, pop_en, stack_data_in1, stack_data_in2,
    output stack_data_out1, stack_data_out2, stack_pointer, count, busy, done,
           full, empty, overflow_err, underflow_err, protocol_err
  );
endinterface

// File: rtl/qs_range_stack.sv
// qs_range_stack: edge-triggered (lo,hi) push/pop stack with fixed-latency done handshake
module qs_range_stack #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 16,
  parameter int LAT       = 4
) (
  input logic               clk,
  input logic               reset_n,
  qs_range_stack_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;
  state_t               state_q, state_d;
  logic [AW:0]          sp_q, sp_d;
  logic [4:0]           count_q, count_d;
  logic [WORD_SIZE-1:0] out1_q, out1_d, out2_q, out2_d, in1_q, in1_d, in2_q, in2_d;
  logic                 op_pop_q, op_pop_d;
  logic                 push_prev_q, pop_prev_q;
  logic                 ovf_q, ovf_d, unf_q, unf_d, prot_q, prot_d;
  logic [2*WORD_SIZE-1:0] mem [DEPTH];
  logic                 push_rise, pop_rise, full, empty, mem_we;
  logic [AW-1:0]        top;
  always_comb begin
    push_rise = bus.push_en & ~push_prev_q;
    pop_rise  = bus.pop_en & ~pop_prev_q;
    full      = sp_q == (AW+1)'(DEPTH);
    empty     = sp_q == '0;
    top       = sp_q[AW-1:0] - AW'(1);
    state_d   = state_q;
    sp_d      = sp_q;
    count_d   = (state_q != IDLE && count_q != 5'd31) ? count_q + 5'd1 : count_q;
    out1_d    = out1_q;
    out2_d    = out2_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    op_pop_d  = op_pop_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    prot_d    = prot_q;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (push_rise && pop_rise) prot_d = 1'b1;
        else if (push_rise || pop_rise) begin
          state_d  = EXEC;
          count_d  = 5'd1;
          op_pop_d = pop_rise;
          in1_d    = bus.stack_data_in1;
          in2_d    = bus.stack_data_in2;
        end
      end
      EXEC: begin
        state_d = count_q >= 5'(LAT-2) ? DONE : WAIT;
        if (op_pop_q) begin
          unf_d  = unf_q | empty;
          sp_d   = empty ? sp_q : sp_q - 1'b1;
          out1_d = empty ? out1_q : mem[top][2*WORD_SIZE-1:WORD_SIZE];
          out2_d = empty ? out2_q : mem[top][WORD_SIZE-1:0];
        end else begin
          ovf_d  = ovf_q | full;
          sp_d   = full ? sp_q : sp_q + 1'b1;
          mem_we = !full;
        end
      end
      WAIT: state_d = count_q >= 5'(LAT-2) ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      count_q     <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      op_pop_q    <= 1'b0;
      push_prev_q <= 1'b0;
      pop_prev_q  <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      prot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      count_q     <= count_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      op_pop_q    <= op_pop_d;
      push_prev_q <= bus.push_en;
      pop_prev_q  <= bus.pop_en;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      prot_q      <= prot_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem[sp_q[AW-1:0]] <= {in1_q, in2_q};
  end
  assign bus.stack_data_out1 = out1_q;
  assign bus.stack_data_out2 = out2_q;
  assign bus.stack_pointer   = WORD_SIZE'(sp_q);
  assign bus.count           = count_q;
  assign bus.busy            = state_q != IDLE;
  assign bus.done            = state_q == DONE;
  assign bus.full            = full;
  assign bus.empty           = empty;
  assign bus.overflow_err    = ovf_q;
  assign bus.underflow_err   = unf_q;
  assign bus.protocol_err    = prot_q;
endmodule

// File: tb/tb_qs_range_stack.sv
// tb_qs_range_stack: scoreboard bench for the (lo,hi) range stack
module tb_qs_range_stack;
  localparam int W = 16;
  localparam int DEPTH = 16;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_asrt = 0;
  int n_fail = 0;
  logic [31:0] stk [$];
  logic [31:0] sb [$];
  logic [31:0] exp_out = '0;
  logic exp_ovf = 1'b0, exp_unf = 1'b0, exp_prot = 1'b0;
  always #5 clk = ~clk;
  qs_range_stack_if #(.WORD_SIZE(W)) bus ();
  qs_range_stack #(.WORD_SIZE(W), .DEPTH(DEPTH), .LAT(LAT)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    stk.delete();
    sb.delete();
    exp_out = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    exp_prot = 1'b0;
  endtask
  task automatic check_status(input string tag);
    check({tag, "_sp"}, 32'(bus.stack_pointer), 32'(stk.size()));
    check({tag, "_empty"}, 32'(bus.empty), 32'(stk.size() == 0));
    check({tag, "_full"}, 32'(bus.full), 32'(stk.size() == DEPTH));
    check({tag, "_ovf"}, 32'(bus.overflow_err), 32'(exp_ovf));
    check({tag, "_unf"}, 32'(bus.underflow_err), 32'(exp_unf));
    check({tag, "_prot"}, 32'(bus.protocol_err), 32'(exp_prot));
  endtask
  task automatic cmd(input bit is_pop, input logic [W-1:0] lo, input logic [W-1:0] hi);
    int lat;
    @(negedge clk);
    bus.push_en = !is_pop;
    bus.pop_en = is_pop;
    bus.stack_data_in1 = lo;
    bus.stack_data_in2 = hi;
    if (is_pop) begin
      if (stk.size() > 0) exp_out = stk.pop_back();
      else exp_unf = 1'b1;
    end else begin
      if (stk.size() < DEPTH) stk.push_back({lo, hi});
      else exp_ovf = 1'b1;
    end
    sb.push_back(exp_out);
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.push_en = 1'b0;
        bus.pop_en = 1'b0;
        check("busy_exec", 32'(bus.busy), 1);
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check("done_latency", 32'(lat), LAT - 1);
    check("count_done", 32'(bus.count), LAT - 1);
    check("out", {bus.stack_data_out1, bus.stack_data_out2}, sb.pop_front());
    check_status("cmd");
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 0);
    check("busy_idle", 32'(bus.busy), 0);
    check("count_idle", 32'(bus.count), LAT);
  endtask
  initial begin
    int dn;
    bus.push_en = 1'b0;
    bus.pop_en = 1'b0;
    bus.stack_data_in1 = '0;
    bus.stack_data_in2 = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_count", 32'(bus.count), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_out", {bus.stack_data_out1, bus.stack_data_out2}, 0);
    check_status("rst");
    cmd(0, 16'd3, 16'd9);
    cmd(0, 16'd0, 16'd4);
    cmd(0, 16'd6, 16'd9);
    cmd(1, '0, '0);
    cmd(1, '0, '0);
    cmd(1, '0, '0);
    cmd(1, '0, '0);
    @(negedge clk);
    bus.push_en = 1'b1;
    bus.stack_data_in1 = 16'h11;
    bus.stack_data_in2 = 16'h22;
    stk.push_back(32'h0011_0022);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    bus.push_en = 1'b0;
    check("hold_one_done", 32'(dn), 1);
    check_status("hold");
    @(negedge clk);
    bus.push_en = 1'b1;
    bus.pop_en = 1'b1;
    @(negedge clk);
    bus.push_en = 1'b0;
    bus.pop_en = 1'b0;
    check("prot_busy", 32'(bus.busy), 0);
    exp_prot = 1'b1;
    repeat (3) @(negedge clk);
    check_status("prot");
    @(negedge clk);
    bus.push_en = 1'b1;
    bus.stack_data_in1 = 16'h5;
    bus.stack_data_in2 = 16'h7;
    @(negedge clk);
    bus.push_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort_no_done", 32'(dn), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_count", 32'(bus.count), 0);
    check("abort_out", {bus.stack_data_out1, bus.stack_data_out2}, 0);
    check_status("abort");
    cmd(0, 16'hA, 16'hB);
    for (int i = 0; i < DEPTH; i++) cmd(0, W'($urandom), W'($urandom));
    cmd(1, '0, '0);
    cmd(1, '0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
